fetch_sequencer: RTL and testbench

Instruction-fetch controller that sequences the 18-bit program-counter register and the instruction memory port. It reads the PC, issues a memory read at that address, advances the PC, and hands the fetched word to decode through a valid/ready handshake. It applies taken-branch targets by writing the PC, and raises a sticky fault if memory stops responding.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_timeout.sv | 23 ++
 rtl/fetch_sequencer.sv | 86 ++++++++
 tb/tb_fetch_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and state encoding for the instruction-fetch sequencer.
package fetch_pkg;
    localparam int PC_W = 18;
    localparam int TO_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_PC  = 3'd1,
        S_CAP_PC = 3'd2,
        S_MEM    = 3'd3,
        S_INC    = 3'd4,
        S_ISSUE  = 3'd5,
        S_BRANCH = 3'd6,
        S_FAULT  = 3'd7
    } state_t;
endpackage

// File: rtl/fetch_timeout.sv
// fetch_timeout: memory-wait counter; hit flags the enabled cycle that brings the count to TIMEOUT.
module fetch_timeout
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    logic [TO_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= count + 1'b1;
    end

    // Look one step ahead so the FSM leaves MEM on the very edge the count reaches TIMEOUT.
    always_comb hit = en && (count == TO_W'(TIMEOUT - 1));
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences PC read, memory fetch, PC increment and decode handoff,
// applies branch targets and latches a sticky fault when memory stops acknowledging.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int WORD_W  = 18,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              pc_re,
    output logic              pc_wr,
    output logic              pc_inc,
    output logic [PC_W-1:0]   pc_wdata,
    input  logic [PC_W-1:0]   pc_rdata,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              ir_valid,
    output logic [WORD_W-1:0] ir,
    input  logic              ir_ready,
    input  logic              br_valid,
    input  logic [PC_W-1:0]   br_target,
    output logic              br_ack,
    output logic              fault,
    output logic              busy
);
    state_t state, nxt;
    logic   to_hit;

    fetch_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (state == S_CAP_PC),
        .en  (state == S_MEM && !mem_ack),
        .hit (to_hit)
    );

    // A pending branch in ISSUE wins over ir_ready: the fetched word is dropped.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = br_valid ? S_BRANCH : (run ? S_RD_PC : S_IDLE);
            S_RD_PC:  nxt = S_CAP_PC;
            S_CAP_PC: nxt = S_MEM;
            S_MEM:    nxt = mem_ack ? S_INC : (to_hit ? S_FAULT : S_MEM);
            S_INC:    nxt = S_ISSUE;
            S_ISSUE:  nxt = br_valid ? S_BRANCH : (ir_ready ? (run ? S_RD_PC : S_IDLE) : S_ISSUE);
            S_BRANCH: nxt = run ? S_RD_PC : S_IDLE;
            default:  nxt = S_FAULT;
        endcase
    end

    // Outputs are registered from the next state, so each strobe maps to exactly one state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc_re    <= 1'b0;
            pc_wr    <= 1'b0;
            pc_inc   <= 1'b0;
            pc_wdata <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            ir_valid <= 1'b0;
            ir       <= '0;
            br_ack   <= 1'b0;
            fault    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= nxt;
            pc_re    <= nxt == S_RD_PC;
            pc_wr    <= nxt == S_BRANCH;
            pc_inc   <= nxt == S_INC;
            pc_wdata <= nxt == S_BRANCH ? br_target : '0;
            mem_req  <= nxt == S_MEM;
            ir_valid <= nxt == S_ISSUE;
            br_ack   <= nxt == S_BRANCH;
            fault    <= nxt == S_FAULT;
            busy     <= nxt != S_IDLE && nxt != S_FAULT;
            if (state == S_CAP_PC) mem_addr <= pc_rdata;
            if (state == S_MEM && mem_ack) ir <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven fetch/branch/stop vectors plus timeout, reset and random strobe checks.
module tb_fetch_sequencer;
    typedef struct {
        logic        run;
        logic        bv;
        logic [17:0] bt;
        logic        rdy;
        logic [7:0]  fl;
        logic [17:0] addr;
        logic [17:0] ir;
        logic [17:0] wd;
        logic [17:0] pc;
    } vec_t;

    // flag order {pc_re, pc_wr, pc_inc, mem_req, ir_valid, br_ack, busy, fault}
    localparam logic [7:0] F_RE  = 8'h82;
    localparam logic [7:0] F_CAP = 8'h02;
    localparam logic [7:0] F_MEM = 8'h12;
    localparam logic [7:0] F_INC = 8'h22;
    localparam logic [7:0] F_ISS = 8'h0A;
    localparam logic [7:0] F_BR  = 8'h46;
    localparam logic [7:0] F_IDL = 8'h00;
    localparam logic [7:0] F_FLT = 8'h01;

    logic        clk = 1'b0, rst = 1'b0, run = 1'b0, br_valid = 1'b0, ir_ready = 1'b0, no_ack = 1'b0;
    logic [17:0] br_target = '0;
    logic [17:0] pc_rdata, pc_wdata, mem_addr, mem_rdata, ir, pc;
    logic        pc_re, pc_wr, pc_inc, mem_req, mem_ack, ir_valid, br_ack, fault, busy;
    int          checks = 0, errors = 0, wcnt = 0, ack_delay = 0;
    vec_t        tbl[$];

    fetch_sequencer #(.WORD_W(18), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .run(run),
        .pc_re(pc_re), .pc_wr(pc_wr), .pc_inc(pc_inc), .pc_wdata(pc_wdata), .pc_rdata(pc_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_valid(ir_valid), .ir(ir), .ir_ready(ir_ready),
        .br_valid(br_valid), .br_target(br_target), .br_ack(br_ack),
        .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // PC register model: read > write > increment; output is junk except after a read.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= 18'h00010;
            pc_rdata <= '0;
        end else begin
            pc_rdata <= pc_re ? pc : 18'h2D2D2;
            if (!pc_re && pc_wr) pc <= pc_wdata;
            else if (!pc_re && pc_inc) pc <= pc + 18'd1;
        end
    end

    always @(posedge clk) wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
    assign mem_ack   = mem_req && !no_ack && wcnt == ack_delay;
    assign mem_rdata = mem_addr ^ 18'h2ABDD;

    function automatic logic [7:0] flags();
        return {pc_re, pc_wr, pc_inc, mem_req, ir_valid, br_ack, busy, fault};
    endfunction

    function automatic vec_t mk(input logic r, b, input logic [17:0] t, input logic y,
                                input logic [7:0] f, input logic [17:0] a, i, w, p);
        vec_t v;
        v.run = r; v.bv = b; v.bt = t; v.rdy = y; v.fl = f; v.addr = a; v.ir = i; v.wd = w; v.pc = p;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    task automatic step(input logic r, b, input logic [17:0] t, input logic y);
        run = r; br_valid = b; br_target = t; ir_ready = y;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string n);
        chk({n, " flags"}, 32'(flags()), 32'h0);
        chk({n, " mem_addr"}, 32'(mem_addr), 32'h0);
        chk({n, " ir"}, 32'(ir), 32'h0);
        chk({n, " pc_wdata"}, 32'(pc_wdata), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int req_cycles;
        tbl.push_back(mk(1, 0, 0, 0, F_RE,  18'h0,     18'h0,     0, 18'h10));
        tbl.push_back(mk(1, 0, 0, 0, F_CAP, 18'h0,     18'h0,     0, 18'h10));
        tbl.push_back(mk(1, 0, 0, 0, F_MEM, 18'h10,    18'h0,     0, 18'h10));
        tbl.push_back(mk(1, 0, 0, 0, F_INC, 18'h10,    18'h2ABCD, 0, 18'h10));
        tbl.push_back(mk(1, 0, 0, 0, F_ISS, 18'h10,    18'h2ABCD, 0, 18'h11));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(1, 0, 0, 0, F_ISS, 18'h10, 18'h2ABCD, 0, 18'h11));
        tbl.push_back(mk(1, 0, 0, 1, F_RE,  18'h10,    18'h2ABCD, 0, 18'h11));
        tbl.push_back(mk(1, 0, 0, 0, F_CAP, 18'h10,    18'h2ABCD, 0, 18'h11));
        tbl.push_back(mk(1, 0, 0, 0, F_MEM, 18'h11,    18'h2ABCD, 0, 18'h11));
        tbl.push_back(mk(1, 0, 0, 0, F_INC, 18'h11,    18'h2ABCC, 0, 18'h11));
        tbl.push_back(mk(1, 0, 0, 0, F_ISS, 18'h11,    18'h2ABCC, 0, 18'h12));
        tbl.push_back(mk(1, 1, 18'h3FFFF, 1, F_BR, 18'h11, 18'h2ABCC, 18'h3FFFF, 18'h12));
        tbl.push_back(mk(1, 0, 0, 1, F_RE,  18'h11,    18'h2ABCC, 0, 18'h3FFFF));
        tbl.push_back(mk(1, 0, 0, 0, F_CAP, 18'h11,    18'h2ABCC, 0, 18'h3FFFF));
        tbl.push_back(mk(1, 0, 0, 0, F_MEM, 18'h3FFFF, 18'h2ABCC, 0, 18'h3FFFF));
        tbl.push_back(mk(1, 0, 0, 0, F_INC, 18'h3FFFF, 18'h15422, 0, 18'h3FFFF));
        tbl.push_back(mk(1, 0, 0, 0, F_ISS, 18'h3FFFF, 18'h15422, 0, 18'h00000));
        tbl.push_back(mk(1, 0, 0, 1, F_RE,  18'h3FFFF, 18'h15422, 0, 18'h0));
        tbl.push_back(mk(1, 0, 0, 0, F_CAP, 18'h3FFFF, 18'h15422, 0, 18'h0));
        tbl.push_back(mk(1, 0, 0, 0, F_MEM, 18'h0,     18'h15422, 0, 18'h0));
        tbl.push_back(mk(0, 0, 0, 0, F_INC, 18'h0,     18'h2ABDD, 0, 18'h0));
        tbl.push_back(mk(0, 0, 0, 0, F_ISS, 18'h0,     18'h2ABDD, 0, 18'h1));
        tbl.push_back(mk(0, 0, 0, 1, F_IDL, 18'h0,     18'h2ABDD, 0, 18'h1));
        tbl.push_back(mk(0, 0, 0, 0, F_IDL, 18'h0,     18'h2ABDD, 0, 18'h1));
        tbl.push_back(mk(0, 1, 18'h00100, 0, F_BR, 18'h0, 18'h2ABDD, 18'h00100, 18'h1));
        tbl.push_back(mk(0, 0, 0, 0, F_IDL, 18'h0,     18'h2ABDD, 0, 18'h100));
        tbl.push_back(mk(1, 0, 0, 0, F_RE,  18'h0,     18'h2ABDD, 0, 18'h100));

        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].run, tbl[i].bv, tbl[i].bt, tbl[i].rdy);
            chk($sformatf("row%0d flags", i), 32'(flags()), 32'(tbl[i].fl));
            chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            chk($sformatf("row%0d ir", i), 32'(ir), 32'(tbl[i].ir));
            chk($sformatf("row%0d pc_wdata", i), 32'(pc_wdata), 32'(tbl[i].wd));
            chk($sformatf("row%0d pc", i), 32'(pc), 32'(tbl[i].pc));
        end

        // Reset asserted while waiting in MEM drops everything at once.
        no_ack = 1'b1;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("mid mem_req", 32'(mem_req), 32'h1);
        chk("mid mem_addr", 32'(mem_addr), 32'h100);
        #2 rst = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk) rst = 1'b1;
        step(0, 0, 0, 0);
        chk("idle flags", 32'(flags()), 32'(F_IDL));

        // Memory never answers: four request cycles, then sticky fault.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        req_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            step(1, 0, 0, 0);
            if (!mem_req) break;
            req_cycles++;
        end
        chk("timeout req_cycles", 32'(req_cycles), 32'd4);
        chk("timeout flags", 32'(flags()), 32'(F_FLT));
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 18'h00555, 1);
            chk($sformatf("fault hold%0d", k), 32'(flags()), 32'(F_FLT));
        end
        rst = 1'b0;
        #1;
        chk_zero("fault_rst");
        @(negedge clk) rst = 1'b1;
        no_ack = 1'b0;
        br_valid = 1'b0;

        // Random run/branch/ready/ack-delay traffic: PC strobes never overlap.
        for (int k = 0; k < 400; k++) begin
            run = $urandom_range(0, 9) != 0;
            if (!br_valid || br_ack) begin
                br_valid  = $urandom_range(0, 7) == 0;
                br_target = 18'($urandom);
            end
            ir_ready = 1'($urandom_range(0, 1));
            if (!mem_req) ack_delay = $urandom_range(0, 3);
            @(posedge clk);
            #1;
            checks++;
            if ($countones({pc_re, pc_wr, pc_inc}) > 1) begin
                errors++;
                $display("FAIL strobe_excl got %b expected at most one set", {pc_re, pc_wr, pc_inc});
            end
        end
        chk("random no fault", 32'(fault), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
